store_write_buffer: RTL and testbench
=====================================

STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, datapath width; DEPTH, default 4, buffer entries, power of two.
REQ-002 iClk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 iRst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 iStoreValid  input  1  SHALL mean a store request is presented this cycle.
REQ-005 iStoreType  input  InstructionTypes  SHALL select STORE_BYTE, STORE_HALF or STORE_WORD.
REQ-006 iAddress  input  DATA_WIDTH  SHALL be the byte address of the store.
REQ-007 iStoreData  input  DATA_WIDTH  SHALL be the unaligned register data; the LSBs are used.
REQ-008 oStoreReady  output  1  SHALL mean a request is accepted this cycle.
REQ-009 oMisaligned  output  1  SHALL be a one-cycle registered pulse flagging a rejected misaligned store.
REQ-010 iFlush  input  1  SHALL be a level request to drain the buffer completely.
REQ-011 oFlushDone  output  1  SHALL be a one-cycle pulse when a flush completes.
REQ-012 oMemValid, oMemAddress[DATA_WIDTH], oMemData[DATA_WIDTH], oMemByteEn[4]  outputs  SHALL form the memory write request.
REQ-013 iMemReady  input  1  SHALL mean memory accepts the presented write this cycle.
REQ-014 iLoadAddress  input  DATA_WIDTH / oLoadConflict  output  1  SHALL form the load-hazard check.
REQ-015 oCount  output  $clog2(DEPTH)+1  SHALL report the occupied entries; oEmpty and oFull (1 bit each) SHALL be derived from oCount.

Function
REQ-016 A store SHALL be enqueued iff iStoreValid && oStoreReady && the access is aligned.
REQ-017 oStoreReady SHALL equal (oCount<DEPTH) && state!=FLUSH; a same-cycle dequeue SHALL NOT free a slot for that cycle.
REQ-018 Misalignment SHALL be STORE_HALF with iAddress[0]=1, or STORE_WORD with iAddress[1:0]!=0; such a store SHALL NOT be enqueued and SHALL set oMisaligned the next cycle.
REQ-019 Lane alignment, off=iAddress[1:0]: byte: data={4{d[7:0]}}, byteEn=4'b0001<<off; half: data={2{d[15:0]}}, byteEn=4'b0011<<off; word: data=d, byteEn=4'b1111.
REQ-020 Entries SHALL store {iAddress[31:2],2'b00}, aligned data and byteEn; non-store iStoreType values SHALL be ignored.
REQ-021 The FSM SHALL have states IDLE (empty), SEND (head presented) and FLUSH (draining, intake blocked).
REQ-022 Transitions: IDLE->SEND on enqueue; SEND->IDLE when the last entry is accepted and no enqueue occurs; any state->FLUSH on iFlush while non-empty; FLUSH->IDLE on the last acceptance, with oFlushDone pulsed in the following cycle.
REQ-023 iFlush while empty SHALL pulse oFlushDone the next cycle and remain in IDLE.
REQ-024 oMemValid SHALL be 1 whenever the buffer is non-empty; oMemAddress, oMemData and oMemByteEn SHALL come from the head entry and remain stable until iMemReady.
REQ-025 The head SHALL dequeue on oMemValid && iMemReady; the minimum latency from enqueue to oMemValid SHALL be 1 cycle.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; an enqueue and a dequeue in the same cycle SHALL leave oCount unchanged.
REQ-027 oLoadConflict SHALL be combinational: 1 iff any valid entry's word address equals iLoadAddress[31:2].

Reset
REQ-028 While iRst_n=0: the pointers and oCount SHALL be 0, the state IDLE, and oMemValid, oMisaligned, oFlushDone and oLoadConflict 0.
REQ-029 Reset asserted mid-transfer SHALL discard all pending entries without completing them.

Structure
REQ-030 The InstructionTypes store members, the StoreBufState enum and the STORE_BUF_DEPTH constant SHALL reside in the shared ControlTypeDefs package.
REQ-031 Lane alignment SHALL be a combinational sub-module named store_align; the FIFO and FSM SHALL remain in the top module.

Verification
REQ-032 SB, addr 0x103, data 0xAB -> oMemAddress=0x100, oMemData=0xABABABAB, oMemByteEn=4'b1000.
REQ-033 SH, addr 0x201 -> no enqueue, oMisaligned=1 for exactly one cycle, oCount=0.
REQ-034 Five SWs with iMemReady=0 -> oFull after the fourth, oStoreReady=0, fifth rejected; then iMemReady=1 -> four writes in order, oEmpty.
REQ-035 Three entries queued, iFlush=1, iMemReady toggled -> no new stores accepted; oFlushDone pulses once after the third acceptance.
REQ-036 SW 0x40 pending, iLoadAddress=0x42 -> oLoadConflict=1; after drain -> 0.
REQ-037 iRst_n pulsed low with two entries pending -> oMemValid=0, oCount=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/store_write_buffer_pkg.sv
// Shared control typedefs for the store path.
//   InstructionTypes : instruction class presented with a store request
//   StoreBufState    : store write buffer FSM encoding
//   STORE_BUF_DEPTH  : default number of buffer entries
package ControlTypeDefs;

  localparam int STORE_BUF_DEPTH = 4;

  typedef enum logic [2:0] {
    INSTR_NOP  = 3'd0,
    LOAD_BYTE  = 3'd1,
    LOAD_HALF  = 3'd2,
    LOAD_WORD  = 3'd3,
    STORE_BYTE = 3'd4,
    STORE_HALF = 3'd5,
    STORE_WORD = 3'd6,
    INSTR_ALU  = 3'd7
  } InstructionTypes;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    FLUSH = 2'd2
  } StoreBufState;

endpackage

// File: rtl/store_write_buffer_align.sv
// store_align: combinational lane alignment of store data.
//   i_type       : instruction class (only STORE_* produce a store)
//   i_offset     : byte offset within the word (address bits [1:0])
//   i_data       : register data, LSB-justified
//   o_data       : data replicated onto the addressed lanes
//   o_byte_en    : per-byte write enables
//   o_is_store   : i_type is one of the store classes
//   o_misaligned : store whose offset does not match its size
module store_align
  import ControlTypeDefs::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  InstructionTypes       i_type,
  input  logic [1:0]            i_offset,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [3:0]            o_byte_en,
  output logic                  o_is_store,
  output logic                  o_misaligned
);

  always_comb begin
    o_data       = '0;
    o_byte_en    = '0;
    o_is_store   = 1'b0;
    o_misaligned = 1'b0;
    case (i_type)
      STORE_BYTE: begin
        o_is_store = 1'b1;
        o_data     = {(DATA_WIDTH/8){i_data[7:0]}};
        o_byte_en  = 4'b0001 << i_offset;
      end
      STORE_HALF: begin
        o_is_store   = 1'b1;
        o_misaligned = i_offset[0];
        o_data       = {(DATA_WIDTH/16){i_data[15:0]}};
        o_byte_en    = 4'b0011 << i_offset;
      end
      STORE_WORD: begin
        o_is_store   = 1'b1;
        o_misaligned = |i_offset;
        o_data       = i_data;
        o_byte_en    = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_write_buffer.sv
// store_write_buffer: FIFO of aligned stores draining to a memory write port.
//   iClk/iRst_n                 : clock, async active-low reset
//   iStoreValid/iStoreType/iAddress/iStoreData : store request
//   oStoreReady/oMisaligned     : intake ready, rejected-misaligned pulse
//   iFlush/oFlushDone           : drain request, completion pulse
//   oMemValid/oMemAddress/oMemData/oMemByteEn/iMemReady : memory write port
//   iLoadAddress/oLoadConflict  : load hazard check against pending words
//   oCount/oEmpty/oFull         : occupancy
module store_write_buffer
  import ControlTypeDefs::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = STORE_BUF_DEPTH
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  input  logic                    iStoreValid,
  input  InstructionTypes         iStoreType,
  input  logic [DATA_WIDTH-1:0]   iAddress,
  input  logic [DATA_WIDTH-1:0]   iStoreData,
  output logic                    oStoreReady,
  output logic                    oMisaligned,
  input  logic                    iFlush,
  output logic                    oFlushDone,
  output logic                    oMemValid,
  output logic [DATA_WIDTH-1:0]   oMemAddress,
  output logic [DATA_WIDTH-1:0]   oMemData,
  output logic [3:0]              oMemByteEn,
  input  logic                    iMemReady,
  input  logic [DATA_WIDTH-1:0]   iLoadAddress,
  output logic                    oLoadConflict,
  output logic [$clog2(DEPTH):0]  oCount,
  output logic                    oEmpty,
  output logic                    oFull
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] LP_ONE   = CW'(1);

  StoreBufState            r_state, w_state_nxt;
  logic [PW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic [DEPTH-1:0]        r_valid;
  logic [DATA_WIDTH-1:0]   r_addr [DEPTH];
  logic [DATA_WIDTH-1:0]   r_data [DEPTH];
  logic [3:0]              r_be   [DEPTH];
  logic                    r_misaligned, r_flush_done;

  logic [DATA_WIDTH-1:0]   w_al_data;
  logic [3:0]              w_al_be;
  logic                    w_is_store, w_misaligned;
  logic                    w_accept, w_enq, w_deq, w_last_deq, w_flush_done_nxt;
  logic                    w_unused_load_offset;

  store_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .i_type       (iStoreType),
    .i_offset     (iAddress[1:0]),
    .i_data       (iStoreData),
    .o_data       (w_al_data),
    .o_byte_en    (w_al_be),
    .o_is_store   (w_is_store),
    .o_misaligned (w_misaligned)
  );

  assign w_unused_load_offset = ^iLoadAddress[1:0];

  assign oMemValid   = (r_count != '0);
  assign oEmpty      = (r_count == '0);
  assign oFull       = (r_count == LP_DEPTH);
  assign oCount      = r_count;
  assign oMemAddress = r_addr[r_rd_ptr];
  assign oMemData    = r_data[r_rd_ptr];
  assign oMemByteEn  = r_be[r_rd_ptr];
  assign oMisaligned = r_misaligned;
  assign oFlushDone  = r_flush_done;

  assign w_accept   = iStoreValid && oStoreReady && w_is_store;
  assign w_enq      = w_accept && !w_misaligned;
  assign w_deq      = oMemValid && iMemReady;
  assign w_last_deq = w_deq && (r_count == LP_ONE);

  // FSM: state register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM: next state. A flush raised in the same cycle that empties the
  // buffer (or while it is empty) completes immediately instead of
  // entering FLUSH with nothing left to drain.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_enq) w_state_nxt = iFlush ? FLUSH : SEND;
      SEND: begin
        if (iFlush)                     w_state_nxt = (w_last_deq && !w_enq) ? IDLE : FLUSH;
        else if (w_last_deq && !w_enq)  w_state_nxt = IDLE;
      end
      FLUSH:   if (w_last_deq) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    oStoreReady      = (r_count < LP_DEPTH) && (r_state != FLUSH);
    w_flush_done_nxt = 1'b0;
    case (r_state)
      IDLE:    w_flush_done_nxt = iFlush;
      SEND:    w_flush_done_nxt = iFlush && w_last_deq && !w_enq;
      FLUSH:   w_flush_done_nxt = w_last_deq;
      default: w_flush_done_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_valid      <= '0;
      r_misaligned <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_misaligned <= w_accept && w_misaligned;
      r_flush_done <= w_flush_done_nxt;
      if (w_enq) begin
        r_wr_ptr          <= r_wr_ptr + PW'(1);
        r_valid[r_wr_ptr] <= 1'b1;
      end
      if (w_deq) begin
        r_rd_ptr          <= r_rd_ptr + PW'(1);
        r_valid[r_rd_ptr] <= 1'b0;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + LP_ONE;
        2'b01:   r_count <= r_count - LP_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload needs no reset; r_valid qualifies every use.
  always_ff @(posedge iClk) begin
    if (w_enq) begin
      r_addr[r_wr_ptr] <= {iAddress[DATA_WIDTH-1:2], 2'b00};
      r_data[r_wr_ptr] <= w_al_data;
      r_be[r_wr_ptr]   <= w_al_be;
    end
  end

  always_comb begin
    oLoadConflict = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i][DATA_WIDTH-1:2] == iLoadAddress[DATA_WIDTH-1:2]))
        oLoadConflict = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;
  import ControlTypeDefs::*;

  logic            iClk = 1'b0;
  logic            iRst_n;
  logic            iStoreValid;
  InstructionTypes iStoreType;
  logic [31:0]     iAddress, iStoreData;
  logic            oStoreReady, oMisaligned;
  logic            iFlush, oFlushDone;
  logic            oMemValid;
  logic [31:0]     oMemAddress, oMemData;
  logic [3:0]      oMemByteEn;
  logic            iMemReady;
  logic [31:0]     iLoadAddress;
  logic            oLoadConflict;
  logic [2:0]      oCount;
  logic            oEmpty, oFull;

  store_write_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStoreValid(iStoreValid), .iStoreType(iStoreType),
    .iAddress(iAddress), .iStoreData(iStoreData), .oStoreReady(oStoreReady),
    .oMisaligned(oMisaligned), .iFlush(iFlush), .oFlushDone(oFlushDone),
    .oMemValid(oMemValid), .oMemAddress(oMemAddress), .oMemData(oMemData),
    .oMemByteEn(oMemByteEn), .iMemReady(iMemReady), .iLoadAddress(iLoadAddress),
    .oLoadConflict(oLoadConflict), .oCount(oCount), .oEmpty(oEmpty), .oFull(oFull)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  n_writes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory-side monitor: a write is taken at the coming rising edge.
  always @(negedge iClk) begin
    if (iRst_n && oMemValid && iMemReady) begin
      wr_t e;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("mem_addr", oMemAddress, e.addr);
        chk("mem_data", oMemData, e.data);
        chk("mem_be", 32'(oMemByteEn), 32'(e.be));
        n_writes++;
      end
    end
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic do_store(input InstructionTypes t, input logic [31:0] a, input logic [31:0] d,
                          input logic exp_rdy, input logic exp_enq,
                          input logic [31:0] exp_d, input logic [3:0] exp_be);
    iStoreValid = 1'b1;
    iStoreType  = t;
    iAddress    = a;
    iStoreData  = d;
    #1;
    chk("store_ready", 32'(oStoreReady), 32'(exp_rdy));
    if (exp_enq) sb.push_back('{addr: {a[31:2], 2'b00}, data: exp_d, be: exp_be});
    @(posedge iClk);
    #1;
    iStoreValid = 1'b0;
    iStoreType  = INSTR_NOP;
  endtask

  initial begin
    int pulses;
    int w0;
    iRst_n = 1'b0; iStoreValid = 1'b0; iStoreType = INSTR_NOP; iAddress = '0;
    iStoreData = '0; iFlush = 1'b0; iMemReady = 1'b0; iLoadAddress = '0;
    repeat (2) tick();
    chk("rst_count", 32'(oCount), 32'd0);
    chk("rst_memvalid", 32'(oMemValid), 32'd0);
    chk("rst_misaligned", 32'(oMisaligned), 32'd0);
    chk("rst_flushdone", 32'(oFlushDone), 32'd0);
    chk("rst_conflict", 32'(oLoadConflict), 32'd0);
    chk("rst_empty", 32'(oEmpty), 32'd1);
    iRst_n = 1'b1;
    tick();

    // Byte store to the top lane, then drain it
    do_store(STORE_BYTE, 32'h103, 32'hAB, 1'b1, 1'b1, 32'hABABABAB, 4'b1000);
    chk("sb_count", 32'(oCount), 32'd1);
    chk("sb_memvalid", 32'(oMemValid), 32'd1);
    chk("sb_addr", oMemAddress, 32'h100);
    chk("sb_data", oMemData, 32'hABABABAB);
    chk("sb_be", 32'(oMemByteEn), 32'h8);
    iLoadAddress = 32'h102; #1;
    chk("sb_conflict_hit", 32'(oLoadConflict), 32'd1);
    iLoadAddress = 32'h104; #1;
    chk("sb_conflict_miss", 32'(oLoadConflict), 32'd0);
    iMemReady = 1'b1;
    tick();
    iMemReady = 1'b0;
    chk("sb_drained", 32'(oEmpty), 32'd1);

    // Misaligned and non-store requests are not enqueued
    do_store(STORE_HALF, 32'h201, 32'h1234, 1'b1, 1'b0, 32'h0, 4'h0);
    chk("mis_pulse", 32'(oMisaligned), 32'd1);
    chk("mis_count", 32'(oCount), 32'd0);
    tick();
    chk("mis_pulse_end", 32'(oMisaligned), 32'd0);
    do_store(STORE_WORD, 32'h102, 32'h1, 1'b1, 1'b0, 32'h0, 4'h0);
    chk("mis_word", 32'(oMisaligned), 32'd1);
    do_store(LOAD_WORD, 32'h300, 32'h1, 1'b1, 1'b0, 32'h0, 4'h0);
    chk("nonstore_mis", 32'(oMisaligned), 32'd0);
    chk("nonstore_count", 32'(oCount), 32'd0);

    // Fill to full with memory stalled, fifth store rejected
    do_store(STORE_WORD, 32'h10, 32'hD0D0D0D0, 1'b1, 1'b1, 32'hD0D0D0D0, 4'b1111);
    do_store(STORE_HALF, 32'h22, 32'hBEEF, 1'b1, 1'b1, 32'hBEEFBEEF, 4'b1100);
    do_store(STORE_BYTE, 32'h31, 32'h5A, 1'b1, 1'b1, 32'h5A5A5A5A, 4'b0010);
    chk("fill_count3", 32'(oCount), 32'd3);
    do_store(STORE_WORD, 32'h40, 32'h12345678, 1'b1, 1'b1, 32'h12345678, 4'b1111);
    chk("fill_full", 32'(oFull), 32'd1);
    chk("fill_count4", 32'(oCount), 32'd4);
    do_store(STORE_WORD, 32'h50, 32'hFFFF0000, 1'b0, 1'b0, 32'h0, 4'h0);
    chk("fill_reject_count", 32'(oCount), 32'd4);
    iLoadAddress = 32'h42; #1;
    chk("fill_conflict", 32'(oLoadConflict), 32'd1);
    w0 = n_writes;
    iMemReady = 1'b1;
    for (int i = 0; i < 20 && !oEmpty; i++) tick();
    chk("drain_empty", 32'(oEmpty), 32'd1);
    chk("drain_writes", 32'(n_writes - w0), 32'd4);
    chk("drain_conflict", 32'(oLoadConflict), 32'd0);

    // Enqueue and dequeue in the same cycle leave the count unchanged
    do_store(STORE_WORD, 32'h60, 32'h60606060, 1'b1, 1'b1, 32'h60606060, 4'b1111);
    chk("pass_count1", 32'(oCount), 32'd1);
    do_store(STORE_WORD, 32'h64, 32'h64646464, 1'b1, 1'b1, 32'h64646464, 4'b1111);
    chk("pass_same", 32'(oCount), 32'd1);
    tick();
    chk("pass_empty", 32'(oEmpty), 32'd1);
    iMemReady = 1'b0;

    // Flush of three pending entries with a toggling memory ready
    do_store(STORE_WORD, 32'h80, 32'h80, 1'b1, 1'b1, 32'h80, 4'b1111);
    do_store(STORE_WORD, 32'h84, 32'h84, 1'b1, 1'b1, 32'h84, 4'b1111);
    do_store(STORE_WORD, 32'h88, 32'h88, 1'b1, 1'b1, 32'h88, 4'b1111);
    iFlush = 1'b1;
    tick();
    iFlush = 1'b0;
    chk("flush_ready", 32'(oStoreReady), 32'd0);
    do_store(STORE_WORD, 32'h90, 32'h90, 1'b0, 1'b0, 32'h0, 4'h0);
    chk("flush_count", 32'(oCount), 32'd3);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      iMemReady = ~iMemReady;
      tick();
      if (oFlushDone) begin
        pulses++;
        chk("flush_done_empty", 32'(oEmpty), 32'd1);
      end
    end
    iMemReady = 1'b0;
    chk("flush_pulses", 32'(pulses), 32'd1);
    chk("flush_ready_after", 32'(oStoreReady), 32'd1);

    // Flush while empty
    iFlush = 1'b1;
    tick();
    iFlush = 1'b0;
    chk("flush_empty_pulse", 32'(oFlushDone), 32'd1);
    tick();
    chk("flush_empty_end", 32'(oFlushDone), 32'd0);

    // Asynchronous reset with two entries pending
    do_store(STORE_WORD, 32'hA0, 32'hA0, 1'b1, 1'b1, 32'hA0, 4'b1111);
    do_store(STORE_BYTE, 32'hA4, 32'hA4, 1'b1, 1'b1, 32'hA4A4A4A4, 4'b0001);
    chk("rst2_count_before", 32'(oCount), 32'd2);
    #2;
    iRst_n = 1'b0;
    #1;
    chk("arst_memvalid", 32'(oMemValid), 32'd0);
    chk("arst_count", 32'(oCount), 32'd0);
    sb.delete();
    tick();
    iRst_n = 1'b1;
    iMemReady = 1'b1;
    tick();
    chk("arst_stay_empty", 32'(oEmpty), 32'd1);
    iMemReady = 1'b0;
    chk("sb_final_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
